// File: rtl/rtp_pkg.sv
// Shared types and constants for the ray-tracing processor slice.
// Optional build macro: RTP_EARLY_SKIP_EN (see rtp_top).
package rtp_pkg;

   typedef enum logic [3:0] {
      ST_LOAD_RAY,
      ST_FETCH_TRI,
      ST_DOT,
      ST_DIV,
      ST_DIV_WAIT,
      ST_CMP,
      ST_NEXT,
      ST_RAY_DONE,
      ST_FINISH
   } rtp_state_e;

   localparam logic [15:0]  NO_HIT_IDX = 16'hFFFF;
   localparam int unsigned  FRAC_BITS  = 16;
   localparam logic [31:0]  ONE_Q16    = 32'h0001_0000;

   typedef logic signed [31:0] q16_t;

   // Full-precision signed product of two Q16.16 values (Q32.32 result).
   function automatic logic signed [63:0] q16_mul(input q16_t a, input q16_t b);
      logic signed [63:0] a64;
      logic signed [63:0] b64;
      a64 = a;
      b64 = b;
      return a64 * b64;
   endfunction

   // Magnitude as unsigned; the most negative value maps to 2^31.
   function automatic logic [31:0] q16_abs(input q16_t v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/rtp_fxdiv.sv
// Serial signed Q16.16 divider: quot = (|num| << 16) / |den|, restoring, one bit per cycle.
module rtp_fxdiv
   import rtp_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 48
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  q16_t num,
   input  q16_t den,
   output logic busy,
   output logic done,
   output q16_t quot
);

   localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          neg_q, neg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [47:0]   dvd_q, dvd_d;
   logic [31:0]   rem_q, rem_d;
   logic [31:0]   dsr_q, dsr_d;
   logic [32:0]   rem_sh;
   logic          borrow;
   logic [31:0]   rem_sub;

   // One restoring step per cycle; quotient bits shift into the dividend register.
   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      neg_d  = neg_q;
      cnt_d  = cnt_q;
      dvd_d  = dvd_q;
      rem_d  = rem_q;
      dsr_d  = dsr_q;
      rem_sh = {rem_q, dvd_q[47]};
      {borrow, rem_sub} = rem_sh - {1'b0, dsr_q};
      if (busy_q) begin
         dvd_d = {dvd_q[46:0], ~borrow};
         rem_d = borrow ? rem_sh[31:0] : rem_sub;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(DIV_CYCLES);
         dvd_d  = {q16_abs(num), {FRAC_BITS{1'b0}}};
         rem_d  = '0;
         dsr_d  = q16_abs(den);
         neg_d  = num[31] ^ den[31];
      end
   end

   // Divider state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         neg_q  <= 1'b0;
         cnt_q  <= '0;
         dvd_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         neg_q  <= neg_d;
         cnt_q  <= cnt_d;
         dvd_q  <= dvd_d;
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = neg_q ? -dvd_q[31:0] : dvd_q[31:0];

endmodule

// File: rtl/rtp_rom.sv
// Generic 32-bit synchronous-read ROM; contents preloaded externally through `mem`.
module rtp_rom #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clock,
   input  logic [AW-1:0] addr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   // Read the addressed word.
   always_comb begin
      rdata_d = mem[addr];
   end

   // Register the read data (1-cycle latency).
   always_ff @(posedge clock) begin
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/rtp_top.sv
// Brute-force ray/plane intersection processor (Q16.16): closest hit per ray.
// Optional build macro: RTP_EARLY_SKIP_EN -- also skip divides whose t can never be positive.
module rtp_top
   import rtp_pkg::*;
#(
   parameter int unsigned NUM_RAYS   = 4,
   parameter int unsigned NUM_TRIS   = 4,
   parameter int unsigned DIV_CYCLES = 48
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] io_hitT,
   output logic [31:0] io_ray_id_triangle,
   output logic        io_rtp_finish,
   output logic [63:0] io_counter_fdiv
);

   localparam int unsigned RAW = (NUM_RAYS > 1) ? $clog2(NUM_RAYS) : 1;
   localparam int unsigned TAW = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;

   rtp_state_e  state_q, state_d;
   logic [15:0] ray_q, ray_d;
   logic [15:0] tri_q, tri_d;
   q16_t        best_t_q, best_t_d;
   logic [15:0] best_idx_q, best_idx_d;
   q16_t        num_q, num_d;
   q16_t        den_q, den_d;
   q16_t        t_q, t_d;
   logic [31:0] hit_t_q, hit_t_d;
   logic [31:0] ray_id_tri_q, ray_id_tri_d;
   logic        finish_q, finish_d;
   logic [63:0] cnt_fdiv_q, cnt_fdiv_d;

   q16_t ray_ox, ray_oy, ray_oz, ray_dx, ray_dy, ray_dz, ray_hitt;
   q16_t tri_x, tri_y, tri_z, tri_w;
   q16_t dot_o, dot_d;
   logic skip_div;
   logic div_start, div_busy, div_done;
   q16_t div_quot;

   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_origx (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_ox));
   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_origy (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_oy));
   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_origz (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_oz));
   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_dirx  (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_dx));
   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_diry  (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_dy));
   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_dirz  (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_dz));
   rtp_rom #(.DEPTH(NUM_RAYS), .AW(RAW)) Ray_hitT  (.clock(clock), .addr(ray_q[RAW-1:0]), .rdata(ray_hitt));
   rtp_rom #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_x (.clock(clock), .addr(tri_q[TAW-1:0]), .rdata(tri_x));
   rtp_rom #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_y (.clock(clock), .addr(tri_q[TAW-1:0]), .rdata(tri_y));
   rtp_rom #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_z (.clock(clock), .addr(tri_q[TAW-1:0]), .rdata(tri_z));
   rtp_rom #(.DEPTH(NUM_TRIS), .AW(TAW)) TRI_RAM_w (.clock(clock), .addr(tri_q[TAW-1:0]), .rdata(tri_w));

   rtp_fxdiv #(.DIV_CYCLES(DIV_CYCLES)) u_fxdiv (
      .clock(clock),
      .reset(reset),
      .start(div_start),
      .num  (num_q),
      .den  (den_q),
      .busy (div_busy),
      .done (div_done),
      .quot (div_quot)
   );

   // Plane dot products, 64-bit accumulate then arithmetic shift back to Q16.16.
   always_comb begin
      dot_o = q16_t'((q16_mul(ray_ox, tri_x) + q16_mul(ray_oy, tri_y) + q16_mul(ray_oz, tri_z)) >>> FRAC_BITS);
      dot_d = q16_t'((q16_mul(ray_dx, tri_x) + q16_mul(ray_dy, tri_y) + q16_mul(ray_dz, tri_z)) >>> FRAC_BITS);
   end

   // Decide whether the divide for this triangle can be skipped.
`ifdef RTP_EARLY_SKIP_EN
   assign skip_div = (den_q == '0) || (num_q == '0) || (num_q[31] != den_q[31]);
`else
   assign skip_div = (den_q == '0);
`endif

   // Sequencer: walk every triangle for every ray, keep the closest positive hit.
   // The ray ROM address only changes at RAY_DONE, so ray words stay valid at the
   // ROM outputs for the whole ray; best_t is seeded one cycle after LOAD_RAY.
   always_comb begin
      state_d      = state_q;
      ray_d        = ray_q;
      tri_d        = tri_q;
      best_t_d     = best_t_q;
      best_idx_d   = best_idx_q;
      num_d        = num_q;
      den_d        = den_q;
      t_d          = t_q;
      hit_t_d      = hit_t_q;
      ray_id_tri_d = ray_id_tri_q;
      finish_d     = finish_q;
      cnt_fdiv_d   = cnt_fdiv_q;
      div_start    = 1'b0;
      case (state_q)
         ST_LOAD_RAY: begin
            best_idx_d = NO_HIT_IDX;
            tri_d      = '0;
            state_d    = ST_FETCH_TRI;
         end
         ST_FETCH_TRI: begin
            if (tri_q == '0) begin
               best_t_d = ray_hitt;
            end
            state_d = ST_DOT;
         end
         ST_DOT: begin
            num_d   = tri_w - dot_o;
            den_d   = dot_d;
            state_d = ST_DIV;
         end
         ST_DIV: begin
            if (skip_div) begin
               state_d = ST_NEXT;
            end else if (!div_busy) begin
               div_start  = 1'b1;
               cnt_fdiv_d = cnt_fdiv_q + 64'd1;
               state_d    = ST_DIV_WAIT;
            end
         end
         ST_DIV_WAIT: begin
            if (div_done) begin
               t_d     = div_quot;
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            if ((t_q > 0) && (t_q < best_t_q)) begin
               best_t_d   = t_q;
               best_idx_d = tri_q;
            end
            state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (tri_q == 16'(NUM_TRIS - 1)) begin
               state_d = ST_RAY_DONE;
            end else begin
               tri_d   = tri_q + 16'd1;
               state_d = ST_FETCH_TRI;
            end
         end
         ST_RAY_DONE: begin
            hit_t_d      = best_t_q;
            ray_id_tri_d = {ray_q, best_idx_q};
            if (ray_q == 16'(NUM_RAYS - 1)) begin
               state_d = ST_FINISH;
            end else begin
               ray_d   = ray_q + 16'd1;
               state_d = ST_LOAD_RAY;
            end
         end
         ST_FINISH: begin
            finish_d = 1'b1;
         end
         default: begin
            state_d = ST_LOAD_RAY;
         end
      endcase
   end

   // Sequencer and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_LOAD_RAY;
         ray_q        <= '0;
         tri_q        <= '0;
         best_t_q     <= '0;
         best_idx_q   <= NO_HIT_IDX;
         num_q        <= '0;
         den_q        <= '0;
         t_q          <= '0;
         hit_t_q      <= '0;
         ray_id_tri_q <= '0;
         finish_q     <= 1'b0;
         cnt_fdiv_q   <= '0;
      end else begin
         state_q      <= state_d;
         ray_q        <= ray_d;
         tri_q        <= tri_d;
         best_t_q     <= best_t_d;
         best_idx_q   <= best_idx_d;
         num_q        <= num_d;
         den_q        <= den_d;
         t_q          <= t_d;
         hit_t_q      <= hit_t_d;
         ray_id_tri_q <= ray_id_tri_d;
         finish_q     <= finish_d;
         cnt_fdiv_q   <= cnt_fdiv_d;
      end
   end

   assign io_hitT            = hit_t_q;
   assign io_ray_id_triangle = ray_id_tri_q;
   assign io_rtp_finish      = finish_q;
   assign io_counter_fdiv    = cnt_fdiv_q;

endmodule

// File: tb/tb_rtp_top.sv
// Self-checking bench for rtp_top: directed scenes plus random scenes against a
// plain-arithmetic model of the ray/plane rules.
module tb_rtp_top;

   localparam int unsigned NR = 4;
   localparam int unsigned NT = 4;
   localparam int unsigned DC = 48;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] io_hitT;
   logic [31:0] io_ray_id_triangle;
   logic        io_rtp_finish;
   logic [63:0] io_counter_fdiv;

   rtp_top #(.NUM_RAYS(NR), .NUM_TRIS(NT), .DIV_CYCLES(DC)) dut (
      .clock             (clock),
      .reset             (reset),
      .io_hitT           (io_hitT),
      .io_ray_id_triangle(io_ray_id_triangle),
      .io_rtp_finish     (io_rtp_finish),
      .io_counter_fdiv   (io_counter_fdiv)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   int r_ox[NR], r_oy[NR], r_oz[NR], r_dx[NR], r_dy[NR], r_dz[NR], r_hit[NR];
   int t_x[NT], t_y[NT], t_z[NT], t_w[NT];

   logic [31:0]     exp_hit[NR];
   logic [31:0]     exp_id[NR];
   longint unsigned exp_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: closest positive hit per ray, straight from the plane equation rules.
   task automatic model();
      exp_cnt = 0;
      for (int r = 0; r < NR; r++) begin
         int best_t;
         int best_i;
         best_t = r_hit[r];
         best_i = -1;
         for (int k = 0; k < NT; k++) begin
            longint          dot_o, dot_d;
            int              num, den, t;
            longint unsigned an, ad, q;
            bit              skip;
            dot_o = (longint'(r_ox[r]) * t_x[k] + longint'(r_oy[r]) * t_y[k] + longint'(r_oz[r]) * t_z[k]) >>> 16;
            dot_d = (longint'(r_dx[r]) * t_x[k] + longint'(r_dy[r]) * t_y[k] + longint'(r_dz[r]) * t_z[k]) >>> 16;
            num   = int'(longint'(t_w[k]) - dot_o);
            den   = int'(dot_d);
            skip  = (den == 0);
`ifdef RTP_EARLY_SKIP_EN
            skip  = skip || (num == 0) || ((num < 0) != (den < 0));
`endif
            if (!skip) begin
               exp_cnt++;
               an = (num < 0) ? longint'(-longint'(num)) : longint'(num);
               ad = (den < 0) ? longint'(-longint'(den)) : longint'(den);
               q  = (an << 16) / ad;
               t  = int'(q);
               if ((num < 0) != (den < 0)) t = -t;
               if (t > 0 && t < best_t) begin
                  best_t = t;
                  best_i = k;
               end
            end
         end
         exp_hit[r] = best_t;
         exp_id[r]  = {16'(r), (best_i < 0) ? 16'hFFFF : 16'(best_i)};
      end
   endtask

   task automatic load_mems();
      for (int i = 0; i < NR; i++) begin
         dut.Ray_origx.mem[i] = r_ox[i];
         dut.Ray_origy.mem[i] = r_oy[i];
         dut.Ray_origz.mem[i] = r_oz[i];
         dut.Ray_dirx.mem[i]  = r_dx[i];
         dut.Ray_diry.mem[i]  = r_dy[i];
         dut.Ray_dirz.mem[i]  = r_dz[i];
         dut.Ray_hitT.mem[i]  = r_hit[i];
      end
      for (int i = 0; i < NT; i++) begin
         dut.TRI_RAM_x.mem[i] = t_x[i];
         dut.TRI_RAM_y.mem[i] = t_y[i];
         dut.TRI_RAM_z.mem[i] = t_z[i];
         dut.TRI_RAM_w.mem[i] = t_w[i];
      end
   endtask

   task automatic default_rays();
      for (int i = 0; i < NR; i++) begin
         r_ox[i] = 0; r_oy[i] = 0; r_oz[i] = 0;
         r_dx[i] = 0; r_dy[i] = 0; r_dz[i] = 32'h0001_0000;
         r_hit[i] = 32'h0064_0000;
      end
   endtask

   task automatic set_tri(input int k, input int x, input int y, input int z, input int w);
      t_x[k] = x; t_y[k] = y; t_z[k] = z; t_w[k] = w;
   endtask

   function automatic int rnd_q(input int span_units);
      return int'($urandom_range(0, 2 * span_units * 65536)) - span_units * 65536;
   endfunction

   task automatic random_scene();
      for (int i = 0; i < NR; i++) begin
         r_ox[i] = rnd_q(8); r_oy[i] = rnd_q(8); r_oz[i] = rnd_q(8);
         r_dx[i] = rnd_q(2); r_dy[i] = rnd_q(2); r_dz[i] = rnd_q(2);
         r_hit[i] = int'($urandom_range(32'h0001_0000, 32'h0040_0000));
      end
      for (int k = 0; k < NT; k++) begin
         set_tri(k, rnd_q(2), rnd_q(2), rnd_q(2), rnd_q(16));
      end
   endtask

   // Reset, preload, run to finish and compare every ray result and the counter.
   task automatic run_case(input string name);
      logic [31:0] seen_h[$];
      logic [31:0] seen_id[$];
      logic [31:0] ph, pid;
      bit          done;
      model();
      reset = 1'b1;
      load_mems();
      repeat (2) @(negedge clock);
      chk({name, "/rst_hit"}, io_hitT, 0);
      chk({name, "/rst_id"}, io_ray_id_triangle, 0);
      chk({name, "/rst_fin"}, io_rtp_finish, 0);
      chk({name, "/rst_cnt"}, io_counter_fdiv, 0);
      reset = 1'b0;
      ph   = '0;
      pid  = '0;
      done = 1'b0;
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         @(negedge clock);
         if (io_hitT !== ph || io_ray_id_triangle !== pid) begin
            seen_h.push_back(io_hitT);
            seen_id.push_back(io_ray_id_triangle);
            ph  = io_hitT;
            pid = io_ray_id_triangle;
         end
         if (io_rtp_finish) done = 1'b1;
      end
      chk({name, "/finished"}, done, 1);
      chk({name, "/nrays"}, seen_h.size(), NR);
      for (int r = 0; r < NR; r++) begin
         if (r < seen_h.size()) begin
            chk($sformatf("%s/hit%0d", name, r), seen_h[r], exp_hit[r]);
            chk($sformatf("%s/id%0d", name, r), seen_id[r], exp_id[r]);
         end
      end
      chk({name, "/cnt"}, io_counter_fdiv, exp_cnt);
      repeat (10) @(negedge clock);
      chk({name, "/fin_sticky"}, io_rtp_finish, 1);
      chk({name, "/hit_held"}, io_hitT, exp_hit[NR-1]);
   endtask

   task automatic scene_s1();
      default_rays();
      set_tri(0, 0, 0, 32'h0001_0000, 32'h0005_0000);
      set_tri(1, 0, 0, 32'h0001_0000, 32'h0002_0000);
      set_tri(2, 32'h0001_0000, 0, 0, 32'h0003_0000);
      set_tri(3, 0, 0, 32'h0001_0000, 32'hFFFB_0000);
   endtask

   initial begin
      bit waited;

      // Nearest of two planes wins; den==0 and behind-the-ray planes ignored.
      scene_s1();
      run_case("s1");
      chk("s1/hit_const", io_hitT, 32'h0002_0000);
      chk("s1/id_const", io_ray_id_triangle, 32'h0003_0001);
`ifdef RTP_EARLY_SKIP_EN
      chk("s1/cnt_const", io_counter_fdiv, 8);
`else
      chk("s1/cnt_const", io_counter_fdiv, 12);
`endif

      // Equal distance keeps the earlier triangle.
      default_rays();
      set_tri(0, 0, 0, 32'h0001_0000, 32'h0005_0000);
      set_tri(1, 0, 0, 32'h0001_0000, 32'h0005_0000);
      set_tri(2, 32'h0001_0000, 0, 0, 32'h0005_0000);
      set_tri(3, 0, 32'h0001_0000, 0, 32'h0005_0000);
      run_case("s2");
      chk("s2/id_const", io_ray_id_triangle, 32'h0003_0000);
      chk("s2/hit_const", io_hitT, 32'h0005_0000);

      // All planes parallel to the ray: no hit, no divides.
      default_rays();
      for (int k = 0; k < NT; k++) set_tri(k, 32'h0001_0000, 0, 0, 32'h0005_0000);
      run_case("s3");
      chk("s3/id_const", io_ray_id_triangle, 32'h0003_FFFF);
      chk("s3/hit_const", io_hitT, 32'h0064_0000);
      chk("s3/cnt_const", io_counter_fdiv, 0);

      // Every plane in front: 16 divides.
      default_rays();
      for (int k = 0; k < NT; k++) set_tri(k, 0, 0, 32'h0001_0000, (k + 1) * 32'h0001_0000);
      run_case("s4");
      chk("s4/cnt_const", io_counter_fdiv, 16);

      // Every plane behind (t = -5.0).
      default_rays();
      for (int k = 0; k < NT; k++) set_tri(k, 0, 0, 32'h0001_0000, 32'hFFFB_0000);
      run_case("s5");
`ifdef RTP_EARLY_SKIP_EN
      chk("s5/cnt_const", io_counter_fdiv, 0);
`else
      chk("s5/cnt_const", io_counter_fdiv, 16);
`endif

      for (int n = 0; n < 4; n++) begin
         random_scene();
         run_case($sformatf("rnd%0d", n));
      end

      // Reset pulsed while a divide is in flight, then a full rerun.
      scene_s1();
      reset = 1'b1;
      load_mems();
      repeat (2) @(negedge clock);
      reset  = 1'b0;
      waited = 1'b0;
      for (int cyc = 0; cyc < 5000 && !waited; cyc++) begin
         @(negedge clock);
         if (io_counter_fdiv == 64'd5) waited = 1'b1;
      end
      chk("mid/reached", waited, 1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("mid/hit0", io_hitT, 0);
      chk("mid/id0", io_ray_id_triangle, 0);
      chk("mid/fin0", io_rtp_finish, 0);
      chk("mid/cnt0", io_counter_fdiv, 0);
      run_case("rerun");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
